// File: rtl/nec_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nec_frame_sequencer
// Description : NEC IR receive sequencer. Synchronises the IR line, clears
//               the shared microsecond timer on every mark/space edge,
//               classifies each elapsed width against the NEC nominal timings,
//               and assembles 32-bit frames into an address/command pair.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   system clock; the timer ticks at 1 us in this domain
//   rst          in   asynchronous active-high reset
//   ir_in        in   raw IR receiver output (asynchronous)
//   tmr_count    in   timer count in us, saturating at 16'hFFFF
//   tmr_clr      out  one-cycle timer clear after each detected edge
//   addr         out  decoded address (byte 0), held until next data_valid
//   cmd          out  decoded command (byte 2), held until next data_valid
//   data_valid   out  one-cycle pulse, addr/cmd just updated
//   repeat_valid out  one-cycle pulse, repeat frame received
//   err          out  one-cycle pulse on protocol error or timeout
//   busy         out  high whenever the frame state machine is not idle
// Build option:
//   NEC_REPEAT_EN  defined: repeat-frame recognition compiled in.
//                  undefined: a repeat leader space is an error and
//                  repeat_valid is tied low.
// ============================================================================
module nec_frame_sequencer #(
  parameter bit          IR_ACTIVE_LOW = 1'b1,
  parameter int unsigned LEAD_MARK_US  = 9000,
  parameter int unsigned LEAD_SPACE_US = 4500,
  parameter int unsigned REP_SPACE_US  = 2250,
  parameter int unsigned BIT_MARK_US   = 560,
  parameter int unsigned ONE_SPACE_US  = 1690,
  parameter int unsigned LEAD_TOL_US   = 1000,
  parameter int unsigned BIT_TOL_US    = 200,
  parameter int unsigned TIMEOUT_US    = 12000,
  parameter bit          CHECK_INV     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  input  logic [15:0] tmr_count,
  output logic        tmr_clr,
  output logic [7:0]  addr,
  output logic [7:0]  cmd,
  output logic        data_valid,
  output logic        repeat_valid,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD_M = 3'd1,
    LEAD_S = 3'd2,
    BIT_M  = 3'd3,
    BIT_S  = 3'd4,
    STOP_M = 3'd5,
    REP_M  = 3'd6
  } state_t;

  // Window match with the lower bound clamped at zero; 17-bit arithmetic so
  // nominal+tolerance never wraps against a saturated 16-bit count.
  function automatic logic in_window(input logic [15:0] w,
                                     input int unsigned nom,
                                     input int unsigned tol);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = (nom > tol) ? 17'(nom - tol) : 17'd0;
    hi = 17'(nom + tol);
    return ({1'b0, w} >= lo) && ({1'b0, w} <= hi);
  endfunction

  // Line level when no mark is present; synchroniser resets to it so that
  // releasing reset on an idle line never looks like an edge.
  localparam logic IDLE_LVL = IR_ACTIVE_LOW;

  logic        ir_s1;
  logic        ir_s2;
  logic        mark;
  logic        mark_q;
  logic        mk_start;
  logic        mk_end;
  logic        any_edge;
  logic        timeout;
  logic [15:0] width;
  logic        m_lead;
  logic        m_lead_s;
  logic        m_rep;
  logic        m_bit;
  logic        m_one;
  logic        inv_ok;
  state_t      state;
  logic [4:0]  bitcnt;
  logic [31:0] shreg;

  // Two synchroniser stages, then a registered edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_s1    <= IDLE_LVL;
      ir_s2    <= IDLE_LVL;
      mark_q   <= 1'b0;
      mk_start <= 1'b0;
      mk_end   <= 1'b0;
    end else begin
      ir_s1    <= ir_in;
      ir_s2    <= ir_s1;
      mark_q   <= mark;
      mk_start <= mark & ~mark_q;
      mk_end   <= ~mark & mark_q;
    end
  end

  assign mark     = ir_s2 ^ IR_ACTIVE_LOW;
  assign any_edge = mk_start | mk_end;

  // The timer was cleared after the previous edge, so its count in the
  // edge-detect cycle is the width of the segment that just ended.
  assign width    = tmr_count;

  assign m_lead   = in_window(width, LEAD_MARK_US,  LEAD_TOL_US);
  assign m_lead_s = in_window(width, LEAD_SPACE_US, LEAD_TOL_US);
  assign m_rep    = in_window(width, REP_SPACE_US,  LEAD_TOL_US);
  assign m_bit    = in_window(width, BIT_MARK_US,   BIT_TOL_US);
  assign m_one    = in_window(width, ONE_SPACE_US,  BIT_TOL_US);

  assign timeout  = (state != IDLE) && ({1'b0, tmr_count} >= 17'(TIMEOUT_US));

  assign inv_ok   = !CHECK_INV ||
                    ((shreg[15:8] == ~shreg[7:0]) && (shreg[31:24] == ~shreg[23:16]));

  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= 5'd0;
      shreg      <= 32'd0;
      addr       <= 8'd0;
      cmd        <= 8'd0;
      tmr_clr    <= 1'b0;
      data_valid <= 1'b0;
      err        <= 1'b0;
`ifdef NEC_REPEAT_EN
      repeat_valid <= 1'b0;
`endif
    end else begin
      tmr_clr    <= any_edge;
      data_valid <= 1'b0;
      err        <= 1'b0;
`ifdef NEC_REPEAT_EN
      repeat_valid <= 1'b0;
`endif
      // An edge always takes priority over a coincident timeout. A failure
      // on a mark start resynchronises: that mark may be the next leader.
      if (any_edge) begin
        case (state)
          IDLE: begin
            if (mk_start) state <= LEAD_M;
          end
          LEAD_M: begin
            if (mk_end && m_lead) state <= LEAD_S;
            else begin err <= 1'b1; state <= mk_start ? LEAD_M : IDLE; end
          end
          LEAD_S: begin
            if (mk_start && m_lead_s) begin
              state  <= BIT_M;
              bitcnt <= 5'd0;
            end
`ifdef NEC_REPEAT_EN
            else if (mk_start && m_rep) state <= REP_M;
`else
            else if (mk_start && m_rep) begin err <= 1'b1; state <= IDLE; end
`endif
            else begin err <= 1'b1; state <= mk_start ? LEAD_M : IDLE; end
          end
          BIT_M: begin
            if (mk_end && m_bit) state <= BIT_S;
            else begin err <= 1'b1; state <= mk_start ? LEAD_M : IDLE; end
          end
          BIT_S: begin
            if (mk_start && (m_bit || m_one)) begin
              shreg  <= {m_one, shreg[31:1]};   // LSB-first
              bitcnt <= bitcnt + 5'd1;
              state  <= (bitcnt == 5'd31) ? STOP_M : BIT_M;
            end else begin
              err   <= 1'b1;
              state <= mk_start ? LEAD_M : IDLE;
            end
          end
          STOP_M: begin
            if (mk_end && m_bit) begin
              if (inv_ok) begin
                addr       <= shreg[7:0];
                cmd        <= shreg[23:16];
                data_valid <= 1'b1;
              end else begin
                err <= 1'b1;
              end
              state <= IDLE;
            end else begin
              err   <= 1'b1;
              state <= mk_start ? LEAD_M : IDLE;
            end
          end
`ifdef NEC_REPEAT_EN
          REP_M: begin
            if (mk_end && m_bit) begin
              repeat_valid <= 1'b1;
              state        <= IDLE;
            end else begin
              err   <= 1'b1;
              state <= mk_start ? LEAD_M : IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        err   <= 1'b1;
        state <= IDLE;
      end
    end
  end

`ifndef NEC_REPEAT_EN
  assign repeat_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nec_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nec_frame_sequencer
// Description : Self-checking bench for nec_frame_sequencer. The bench owns
//               the microsecond timer: for each segment it presents the
//               intended width on tmr_count while the edge propagates.
//               Expected results come from frame-level NEC rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nec_frame_sequencer;

  localparam int LM  = 9000;
  localparam int LS  = 4500;
  localparam int RS  = 2250;
  localparam int BM  = 560;
  localparam int ONE = 1690;
  localparam bit CHK = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_in = 1'b1;
  logic [15:0] tmr_count = 16'd0;
  logic        tmr_clr;
  logic [7:0]  addr;
  logic [7:0]  cmd;
  logic        data_valid;
  logic        repeat_valid;
  logic        err;
  logic        busy;

  nec_frame_sequencer #(
    .IR_ACTIVE_LOW (1'b1),
    .CHECK_INV     (CHK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ir_in        (ir_in),
    .tmr_count    (tmr_count),
    .tmr_clr      (tmr_clr),
    .addr         (addr),
    .cmd          (cmd),
    .data_valid   (data_valid),
    .repeat_valid (repeat_valid),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters kept by the monitor; the main sequence only reads them.
  int dv_cnt = 0, rv_cnt = 0, er_cnt = 0, clr_cnt = 0;
  bit excl_bad = 1'b0;
  int n_edges = 0;
  int dv0, rv0, er0, clr0, ed0;
  logic [7:0] exp_addr = 8'd0;
  logic [7:0] exp_cmd  = 8'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid)   dv_cnt++;
      if (repeat_valid) rv_cnt++;
      if (err)          er_cnt++;
      if (tmr_clr)      clr_cnt++;
      if ((int'(data_valid) + int'(repeat_valid) + int'(err)) > 1) excl_bad = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int jit(input int nom, input int mode, input int d);
    if (mode == 0) return nom + d;
    return nom + int'($urandom_range(2 * d)) - d;
  endfunction

  // One line transition; tmr_count holds the segment width until the
  // sequencer has consumed the edge, then the timer restarts from zero.
  task automatic edge_w(input int w);
    tmr_count = 16'(w);
    ir_in     = ~ir_in;
    n_edges++;
    repeat (6) @(posedge clk);
    #1;
    tmr_count = 16'd0;
  endtask

  // Everything after the leader mark has started.
  task automatic send_body(input logic [31:0] data, input int mode, input int d,
                           input int bad_idx, input int bad_w, input int nbits);
    edge_w(jit(LM, mode, d));
    edge_w(jit(LS, mode, d));
    for (int i = 0; i < nbits; i++) begin
      edge_w(jit(BM, mode, d));
      if (i == bad_idx) edge_w(bad_w);
      else              edge_w(jit(data[i] ? ONE : BM, mode, d));
    end
    if (nbits == 32) edge_w(jit(BM, mode, d));
  endtask

  task automatic send_frame(input logic [31:0] data, input int mode, input int d,
                            input int bad_idx, input int bad_w, input int nbits);
    edge_w(0);
    send_body(data, mode, d, bad_idx, bad_w, nbits);
  endtask

  task automatic send_repeat(input int mode, input int d);
    edge_w(0);
    edge_w(jit(LM, mode, d));
    edge_w(jit(RS, mode, d));
    edge_w(jit(BM, mode, d));
  endtask

  task automatic snap();
    dv0 = dv_cnt; rv0 = rv_cnt; er0 = er_cnt; clr0 = clr_cnt; ed0 = n_edges;
  endtask

  // er_e < 0 means "at least one error pulse".
  task automatic finish_frame(input string tag, input int dv_e, input int er_e, input int rv_e,
                              input logic [7:0] a_e, input logic [7:0] c_e);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_dv"}, dv_cnt - dv0, dv_e);
    if (er_e < 0) check({tag, "_err"}, 32'((er_cnt - er0) >= 1), 1);
    else          check({tag, "_err"}, er_cnt - er0, er_e);
    check({tag, "_rep"},  rv_cnt - rv0, rv_e);
    check({tag, "_addr"}, addr, a_e);
    check({tag, "_cmd"},  cmd, c_e);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_clr"},  clr_cnt - clr0, n_edges - ed0);
    check({tag, "_excl"}, excl_bad, 0);
  endtask

  task automatic reset_mid_frame();
    snap();
    send_frame(32'hF708FB04, 0, 0, -1, 0, 11);
    check("mid_busy", busy, 1);
    rst   = 1'b1;
    ir_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_ctl", {tmr_clr, data_valid, repeat_valid, err, busy}, 0);
    check("rst_mid_data", {addr, cmd}, 0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_rel_pulses", (dv_cnt - dv0) + (er_cnt - er0) + (rv_cnt - rv0), 0);
    check("rst_rel_busy", busy, 0);
    exp_addr = 8'd0;
    exp_cmd  = 8'd0;
  endtask

  typedef struct {
    logic [31:0] data;
    int          off;
    bit          dv;
    bit          er;
    logic [7:0]  a;
    logic [7:0]  c;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [31:0] d;
    int          r;
    int          errv;
    bit          ok;

    vecs[0] = '{32'hF708FB04,    0, 1'b1, 1'b0, 8'h04, 8'h08};
    vecs[1] = '{32'hF708FB04,  190, 1'b1, 1'b0, 8'h04, 8'h08};
    vecs[2] = '{32'hF708FB04, -190, 1'b1, 1'b0, 8'h04, 8'h08};
    vecs[3] = '{32'h5CA3AA55,    0, 1'b1, 1'b0, 8'h55, 8'hA3};
    vecs[4] = '{32'hF708FF04,    0, 1'b0, 1'b1, 8'h55, 8'hA3};
    vecs[5] = '{32'hF708FB04,  120, 1'b1, 1'b0, 8'h04, 8'h08};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {tmr_clr, data_valid, repeat_valid, err, busy}, 0);
    check("reset_data", {addr, cmd}, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      if (i == 1) reset_mid_frame();
      snap();
      send_frame(vecs[i].data, 0, vecs[i].off, -1, 0, 32);
      finish_frame($sformatf("vec%0d", i), vecs[i].dv ? 1 : 0, vecs[i].er ? 1 : 0, 0,
                   vecs[i].a, vecs[i].c);
      exp_addr = vecs[i].a;
      exp_cmd  = vecs[i].c;
    end

    // One-space stretched to 1900 us on bit 2 (a '1' bit of address 04).
    snap();
    send_frame(32'hF708FB04, 0, 0, 2, 1900, 32);
    finish_frame("bad_one", 0, -1, 0, exp_addr, exp_cmd);

    // Repeat frame.
    snap();
    send_repeat(0, 0);
`ifdef NEC_REPEAT_EN
    finish_frame("repeat", 0, 0, 1, exp_addr, exp_cmd);
`else
    finish_frame("repeat", 0, 1, 0, exp_addr, exp_cmd);
`endif

    // Line stuck in mark after the leader space.
    snap();
    edge_w(0);
    edge_w(LM);
    edge_w(LS);
    errv = -1;
    for (int v = 11990; v <= 15000; v++) begin
      tmr_count = 16'(v);
      @(posedge clk);
      #1;
      if (err && errv < 0) errv = v;
    end
    edge_w(0);
    check("timeout_at", errv, 12000);
    finish_frame("timeout", 0, 1, 0, exp_addr, exp_cmd);

    // Bad leader space, then a valid frame picked up through resync.
    snap();
    edge_w(0);
    edge_w(LM);
    edge_w(6000);
    send_body(32'h5CA3AA55, 0, 0, -1, 0, 32);
    exp_addr = 8'h55;
    exp_cmd  = 8'hA3;
    finish_frame("resync", 1, 1, 0, exp_addr, exp_cmd);

    // Randomised frames with jitter inside tolerance.
    for (int k = 0; k < 16; k++) begin
      r = int'($urandom_range(9));
      snap();
      if (r == 0) begin
        send_repeat(1, 180);
`ifdef NEC_REPEAT_EN
        finish_frame($sformatf("rnd%0d", k), 0, 0, 1, exp_addr, exp_cmd);
`else
        finish_frame($sformatf("rnd%0d", k), 0, 1, 0, exp_addr, exp_cmd);
`endif
      end else begin
        d = $urandom;
        if (r < 8) begin
          d[15:8]  = ~d[7:0];
          d[31:24] = ~d[23:16];
        end
        send_frame(d, 1, 180, -1, 0, 32);
        ok = !CHK || ((d[15:8] == ~d[7:0]) && (d[31:24] == ~d[23:16]));
        if (ok) begin
          exp_addr = d[7:0];
          exp_cmd  = d[23:16];
        end
        finish_frame($sformatf("rnd%0d", k), ok ? 1 : 0, ok ? 0 : 1, 0, exp_addr, exp_cmd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
